// File: rtl/final_layer_scheduler.sv
// Time-shared XNOR-popcount output layer: streams class weights chunk by chunk from a
// synchronous ROM, accumulates per-class match counts and keeps a running argmax.
module final_layer_scheduler #(
  parameter int unsigned NUM_INPUTS  = 196,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CHUNK       = 28,
  localparam int unsigned NUM_CHUNKS = NUM_INPUTS / CHUNK,
  localparam int unsigned SCORE_W    = $clog2(NUM_INPUTS + 1),
  localparam int unsigned ADDR_W     = $clog2(NUM_CLASSES * NUM_CHUNKS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] data_in,
  output logic                  w_rd_en,
  output logic [ADDR_W-1:0]     w_addr,
  input  logic [CHUNK-1:0]      w_data,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            answer,
  output logic [SCORE_W-1:0]    score
);

  localparam int unsigned ClsW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned ChkW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [ClsW-1:0] LastClass = ClsW'(NUM_CLASSES - 1);
  localparam logic [ChkW-1:0] LastChunk = ChkW'(NUM_CHUNKS - 1);

  if (NUM_INPUTS % CHUNK != 0) begin : g_chunk_check
    $error("NUM_INPUTS must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [NUM_INPUTS-1:0] data_q;
  logic [ClsW-1:0]       class_q, tag_class_q, best_class_q;
  logic [ChkW-1:0]       chunk_q, tag_chunk_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  tag_valid_q, done_q;
  logic [SCORE_W-1:0]    acc_q, best_score_q, score_q;
  logic [3:0]            answer_q;

  logic                  accept, last_issue, finish;
  logic [CHUNK-1:0]      data_chunk;
  logic [SCORE_W-1:0]    partial, acc_base, sum;

  assign accept     = (state_q == StIdle) && start;
  assign last_issue = (state_q == StRun) && (class_q == LastClass) && (chunk_q == LastChunk);
  // The final chunk's tag has drained once tag_valid_q drops while in DRAIN.
  assign finish     = (state_q == StDrain) && !tag_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_issue) state_d = StDrain;
      StDrain: if (!tag_valid_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    data_chunk = data_q[CHUNK*tag_chunk_q +: CHUNK];
    partial    = SCORE_W'($countones(~(w_data ^ data_chunk)));
    acc_base   = (tag_chunk_q == '0) ? '0 : acc_q;
    sum        = acc_base + partial;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q       <= '0;
      class_q      <= '0;
      chunk_q      <= '0;
      addr_q       <= '0;
      tag_valid_q  <= 1'b0;
      tag_class_q  <= '0;
      tag_chunk_q  <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
      done_q       <= 1'b0;
      answer_q     <= '0;
      score_q      <= '0;
    end else begin
      done_q      <= finish;
      tag_valid_q <= (state_q == StRun);
      if (state_q == StRun) begin
        tag_class_q <= class_q;
        tag_chunk_q <= chunk_q;
        if (!last_issue) addr_q <= addr_q + 1'b1;
        if (chunk_q == LastChunk) begin
          chunk_q <= '0;
          if (!last_issue) class_q <= class_q + 1'b1;
        end else begin
          chunk_q <= chunk_q + 1'b1;
        end
      end
      if (accept) begin
        data_q       <= data_in;
        class_q      <= '0;
        chunk_q      <= '0;
        addr_q       <= '0;
        acc_q        <= '0;
        best_score_q <= '0;
        best_class_q <= '0;
      end else if (tag_valid_q) begin
        acc_q <= sum;
        // Strict compare keeps the lower class index on ties.
        if (tag_chunk_q == LastChunk && (tag_class_q == '0 || sum > best_score_q)) begin
          best_score_q <= sum;
          best_class_q <= tag_class_q;
        end
      end
      if (finish) begin
        answer_q <= 4'(best_class_q);
        score_q  <= best_score_q;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign w_rd_en = (state_q == StRun);
  assign w_addr  = addr_q;
  assign done    = done_q;
  assign answer  = answer_q;
  assign score   = score_q;

endmodule
